gray_ptr_sync: RTL and testbench
================================

Name: gray_ptr_sync

Overview:
- Destination-domain receiver for a Gray-coded pointer or counter that is launched from another clock domain.
- Synchronises the Gray word through a parametrised flop chain, then converts it to binary with a registered output stage.
- Monitors successive samples: flags changes and illegal multi-bit steps, reports the binary advance (delta), and keeps a saturating error count.
- Sits on the read or write side of async FIFOs and any other CDC counter crossing.

Parameters:
- SIZE, 4, Gray/binary width; legal range 2..32.
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- ERR_CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  destination-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- gray_async  in  SIZE  Gray value from the foreign domain; asynchronous to clk.
- err_clr  in  1  synchronous clear of err_cnt.
- gray_sync  out  SIZE  last synchroniser stage.
- bin  out  SIZE  binary equivalent of gray_sync, registered.
- bin_valid  out  1  outputs meaningful; warm-up complete.
- changed  out  1  one-cycle pulse when the sample differs from the previous one.
- step_err  out  1  one-cycle pulse when the sample differs from the previous one in more than one bit.
- delta  out  SIZE  binary difference (current − previous), mod 2^SIZE.
- err_cnt  out  ERR_CNT_W  saturating count of step_err pulses.

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-low on rst_n.
- On rst_n low, every flop clears immediately, regardless of clock: sync chain, g_prev, warm counter, bin, bin_valid, changed, step_err, delta, err_cnt.
- Synchroniser: s[0] <= gray_async, s[k] <= s[k-1]; gray_sync = s[SYNC_STAGES-1]. No logic is placed between chain flops.
- g_prev <= gray_sync every cycle.
- Conversion uses constant indices only:
  - b[SIZE-1] = g[SIZE-1]
  - b[i] = b[i+1] ^ g[i], with the loop running downward.
  - No variable part-selects.
- Warm-up counter:
  - Counts clk edges after reset release and saturates at SYNC_STAGES+1.
  - warm = (cnt == SYNC_STAGES+1).
  - Purpose: prevents a false error when gray_async is non-zero at reset release, while g_prev still holds 0.
- Output stage, registered every cycle:
  - bin <= g2b(gray_sync)
  - bin_valid <= warm
  - changed <= warm & (gray_sync != g_prev)
  - step_err <= warm & (popcount(gray_sync ^ g_prev) > 1)
  - delta <= warm ? g2b(gray_sync) − g2b(g_prev) : 0, truncated to SIZE bits.
- Latency:
  - A stable gray_async appears on gray_sync after SYNC_STAGES edges and on bin after SYNC_STAGES+1 edges.
  - bin_valid first rises at edge SYNC_STAGES+2 after reset release.
- Wrap-around:
  - The Gray step 100..0 -> 000..0 gives bin 0, delta 1 and no error.
  - delta is always computed modulo 2^SIZE.
- err_cnt:
  - Increments on each cycle where the step_err condition is true.
  - Holds at 2^ERR_CNT_W − 1.
  - err_clr has priority. If err_clr and an error occur in the same cycle, err_cnt = 1.
  - err_clr alone gives err_cnt = 0.
- A sample that is unchanged gives changed=0, step_err=0, delta=0.
- Reset asserted mid-operation: outputs drop to 0 immediately, and the warm-up restarts on release.

Decomposition:
- Package cdc_gray_pkg holds:
  - function gray2bin, on a 32-bit max width; the caller truncates to SIZE.
  - function popcount.
  - localparam MAX_GRAY_W = 32.
- Sub-module sync_chain, with parameters WIDTH and STAGES; it contains only the flop chain, so CDC tools can identify it.
- Top level holds g_prev, the warm counter, the output stage and err_cnt.

Test Plan:
- Hold gray_async=0000 through reset, SYNC_STAGES=2 -> bin_valid=1 from the 4th edge after release; bin=0; changed, step_err and err_cnt stay 0.
- Hold gray_async=0110 at reset release -> bin=0100 after 3 edges; no step_err; bin_valid=1 at edge 4; err_cnt=0.
- Step Gray 0000,0001,0011,0010,0110, each held for 4 cycles -> bin goes 0,1,2,3,4 (3-cycle latency); one changed pulse per step; delta=1; step_err=0.
- Wrap 1000 -> 0000 (bin 15 -> 0) -> delta=1, changed pulse, step_err=0. Then jump 0000 -> 0011 -> step_err pulse, delta=2, err_cnt=1.
- Force 260 illegal jumps -> err_cnt=255 and held. Then err_clr together with an illegal jump -> err_cnt=1. err_clr alone -> 0.
- Drop rst_n mid-stream while bin=0101, away from a clock edge -> all outputs 0 immediately; after release, warm-up repeats and bin_valid returns at edge 4.

Source files
------------

// File: rtl/cdc_gray_pkg.sv
// Shared helpers for Gray-coded pointer crossings: Gray-to-binary conversion
// and population count, both sized for the widest supported pointer.
package cdc_gray_pkg;

   localparam int MAX_GRAY_W = 32;

   function automatic logic [MAX_GRAY_W-1:0] gray2bin(input logic [MAX_GRAY_W-1:0] g);
      logic [MAX_GRAY_W-1:0] b;
      b = '0;
      b[MAX_GRAY_W-1] = g[MAX_GRAY_W-1];
      for (int i = MAX_GRAY_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [5:0] popcount(input logic [MAX_GRAY_W-1:0] v);
      logic [5:0] c;
      c = 6'd0;
      for (int i = 0; i < MAX_GRAY_W; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/gray_ptr_sync_sync_chain.sv
// Plain multi-flop synchroniser; kept free of any logic between stages so
// CDC tools can recognise it as a synchroniser.
module sync_chain #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_r [STAGES];

   // shift register: stage 0 captures the foreign-domain word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_r[k] <= '0;
         end
      end else begin
         stage_r[0] <= d;
         for (int k = 1; k < STAGES; k++) begin
            stage_r[k] <= stage_r[k-1];
         end
      end
   end

   assign q = stage_r[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Destination-side receiver for a Gray-coded counter: synchronises, converts
// to binary and monitors each new sample for changes and illegal steps.
module gray_ptr_sync
   import cdc_gray_pkg::*;
#(
   parameter int SIZE        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SIZE-1:0]      gray_async,
   input  logic                 err_clr,
   output logic [SIZE-1:0]      gray_sync,
   output logic [SIZE-1:0]      bin,
   output logic                 bin_valid,
   output logic                 changed,
   output logic                 step_err,
   output logic [SIZE-1:0]      delta,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int WARM_MAX = SYNC_STAGES + 1;
   localparam int WARM_W   = $clog2(WARM_MAX + 1);
   localparam logic [WARM_W-1:0]    WARM_TOP = WARM_W'(WARM_MAX);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
   localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

   logic [SIZE-1:0]      g_prev_r;
   logic [WARM_W-1:0]    warm_cnt_r;
   logic                 warm_s;
   logic [SIZE-1:0]      cur_bin_s;
   logic [SIZE-1:0]      prev_bin_s;
   logic [SIZE-1:0]      diff_s;
   logic                 change_s;
   logic                 step_s;
   logic [SIZE-1:0]      delta_s;
   logic [ERR_CNT_W-1:0] err_nxt_s;

   sync_chain #(
      .WIDTH  (SIZE),
      .STAGES (SYNC_STAGES)
   ) u_sync_chain (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (gray_async),
      .q     (gray_sync)
   );

   // previous sample and warm-up counter; warm-up hides the reset-time zero in g_prev
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_prev_r   <= '0;
         warm_cnt_r <= '0;
      end else begin
         g_prev_r <= gray_sync;
         if (warm_cnt_r != WARM_TOP) begin
            warm_cnt_r <= warm_cnt_r + WARM_W'(1);
         end
      end
   end

   assign warm_s     = (warm_cnt_r == WARM_TOP);
   assign cur_bin_s  = SIZE'(gray2bin(MAX_GRAY_W'(gray_sync)));
   assign prev_bin_s = SIZE'(gray2bin(MAX_GRAY_W'(g_prev_r)));
   assign diff_s     = gray_sync ^ g_prev_r;
   assign change_s   = warm_s && (diff_s != '0);
   assign step_s     = warm_s && (popcount(MAX_GRAY_W'(diff_s)) > 6'd1);

   // next delta and saturating error count; a clear wins but still counts a coincident error
   always_comb begin
      delta_s   = '0;
      err_nxt_s = err_cnt;
      if (warm_s) begin
         delta_s = cur_bin_s - prev_bin_s;
      end else begin
         delta_s = '0;
      end
      if (err_clr) begin
         err_nxt_s = step_s ? ERR_ONE : '0;
      end else if (step_s && (err_cnt != ERR_MAX)) begin
         err_nxt_s = err_cnt + ERR_ONE;
      end else begin
         err_nxt_s = err_cnt;
      end
   end

   // registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin       <= '0;
         bin_valid <= 1'b0;
         changed   <= 1'b0;
         step_err  <= 1'b0;
         delta     <= '0;
         err_cnt   <= '0;
      end else begin
         bin       <= cur_bin_s;
         bin_valid <= warm_s;
         changed   <= change_s;
         step_err  <= step_s;
         delta     <= delta_s;
         err_cnt   <= err_nxt_s;
      end
   end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Self-checking bench for gray_ptr_sync: a per-edge reference model built from
// the sampled input history, plus directed literal checks.
`timescale 1ns/1ps
module tb_gray_ptr_sync;

   localparam int SIZE = 4;
   localparam int SS   = 2;
   localparam int EW   = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [SIZE-1:0] gray_async = 4'h0;
   logic            err_clr = 1'b0;
   logic [SIZE-1:0] gray_sync;
   logic [SIZE-1:0] bin;
   logic            bin_valid;
   logic            changed;
   logic            step_err;
   logic [SIZE-1:0] delta;
   logic [EW-1:0]   err_cnt;

   int pass_cnt = 0;
   int total_cnt = 0;

   gray_ptr_sync #(
      .SIZE        (SIZE),
      .SYNC_STAGES (SS),
      .ERR_CNT_W   (EW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .gray_async (gray_async),
      .err_clr    (err_clr),
      .gray_sync  (gray_sync),
      .bin        (bin),
      .bin_valid  (bin_valid),
      .changed    (changed),
      .step_err   (step_err),
      .delta      (delta),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // reference model: history of the Gray word seen at every edge since reset release
   logic [SIZE-1:0] hist[$];
   int              n_edges = 0;
   int              m_err = 0;

   function automatic logic [SIZE-1:0] gs_at(input int k);
      if (k < SS) return '0;
      return hist[k-SS];
   endfunction

   function automatic logic [SIZE-1:0] g2b(input logic [SIZE-1:0] g);
      logic [SIZE-1:0] b;
      b = g;
      for (int s = 1; s < SIZE; s = s * 2) b = b ^ (b >> s);
      return b;
   endfunction

   always @(posedge clk) begin : model
      logic [SIZE-1:0] gc, gp, dd;
      bit v, st;
      if (!rst_n) begin
         hist.delete();
         n_edges = 0;
         m_err = 0;
      end else begin
         hist.push_back(gray_async);
         n_edges++;
      end
      v  = (n_edges >= SS + 2);
      gc = gs_at(n_edges - 1);
      gp = gs_at(n_edges - 2);
      st = v && ($countones(gc ^ gp) > 1);
      dd = v ? (g2b(gc) - g2b(gp)) : 4'h0;
      if (rst_n) begin
         if (err_clr) m_err = st ? 1 : 0;
         else if (st && m_err < 255) m_err++;
      end
      #1;
      chk("m_gray_sync", 32'(gray_sync), 32'(gs_at(n_edges)));
      chk("m_bin",       32'(bin),       32'(g2b(gc)));
      chk("m_bin_valid", 32'(bin_valid), 32'(v));
      chk("m_changed",   32'(changed),   32'(v && (gc != gp)));
      chk("m_step_err",  32'(step_err),  32'(st));
      chk("m_delta",     32'(delta),     32'(dd));
      chk("m_err_cnt",   32'(err_cnt),   32'(m_err));
   end

   task automatic wait_edges(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   logic [SIZE-1:0] seq [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
   logic [SIZE-1:0] rcnt;

   initial begin
      // zero through reset
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(bin_valid), 32'd0);
      chk("rst_err",   32'(err_cnt),   32'd0);
      rst_n = 1'b1;
      wait_edges(3);
      chk("warm0_valid_e3", 32'(bin_valid), 32'd0);
      wait_edges(1);
      chk("warm0_valid_e4", 32'(bin_valid), 32'd1);
      chk("warm0_bin",      32'(bin),       32'd0);

      // non-zero word at reset release
      @(negedge clk);
      rst_n = 1'b0;
      gray_async = 4'b0110;
      #1 chk("rst2_valid", 32'(bin_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_edges(3);
      chk("warm6_bin_e3",   32'(bin),       32'h4);
      chk("warm6_valid_e3", 32'(bin_valid), 32'd0);
      wait_edges(1);
      chk("warm6_valid_e4", 32'(bin_valid), 32'd1);
      chk("warm6_step",     32'(step_err),  32'd0);
      chk("warm6_err",      32'(err_cnt),   32'd0);

      // legal count sequence
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         gray_async = seq[i];
         repeat (3) @(negedge clk);
      end
      chk("seq_bin_end", 32'(bin), 32'h4);

      // wrap 1000 -> 0000, then an illegal jump
      @(negedge clk);
      gray_async = 4'b1000;
      repeat (4) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      gray_async = 4'b0000;
      wait_edges(3);
      chk("wrap_changed", 32'(changed),  32'd1);
      chk("wrap_delta",   32'(delta),    32'd1);
      chk("wrap_step",    32'(step_err), 32'd0);
      chk("wrap_bin",     32'(bin),      32'd0);
      chk("wrap_err",     32'(err_cnt),  32'd0);
      @(negedge clk);
      gray_async = 4'b0011;
      wait_edges(3);
      chk("jump_step",  32'(step_err), 32'd1);
      chk("jump_delta", 32'(delta),    32'd2);
      chk("jump_err",   32'(err_cnt),  32'd1);

      // saturation and clear priority
      for (int i = 0; i < 260; i++) begin
         @(negedge clk);
         gray_async = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      end
      repeat (4) @(negedge clk);
      chk("sat_err", 32'(err_cnt), 32'd255);
      @(negedge clk);
      gray_async = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      err_clr = 1'b1;
      wait_edges(1);
      chk("clr_with_err", 32'(err_cnt), 32'd1);
      chk("clr_step",     32'(step_err), 32'd1);
      wait_edges(1);
      chk("clr_alone", 32'(err_cnt), 32'd0);
      @(negedge clk);
      err_clr = 1'b0;

      // random Gray traffic with occasional jumps and clears
      rcnt = 4'h0;
      for (int i = 0; i < 400; i++) begin
         int r;
         @(negedge clk);
         r = $urandom_range(0, 9);
         if (r < 5) rcnt = rcnt + 4'h1;
         else if (r == 9) rcnt = 4'($urandom);
         gray_async = rcnt ^ (rcnt >> 1);
         err_clr = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      err_clr = 1'b0;

      // reset mid-stream, away from a clock edge
      gray_async = 4'b0111;
      repeat (5) @(negedge clk);
      chk("mid_bin_before", 32'(bin), 32'h5);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_gray_sync", 32'(gray_sync), 32'd0);
      chk("mid_bin",       32'(bin),       32'd0);
      chk("mid_valid",     32'(bin_valid), 32'd0);
      chk("mid_changed",   32'(changed),   32'd0);
      chk("mid_step",      32'(step_err),  32'd0);
      chk("mid_delta",     32'(delta),     32'd0);
      chk("mid_err",       32'(err_cnt),   32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_edges(3);
      chk("mid_rewarm_e3", 32'(bin_valid), 32'd0);
      chk("mid_rebin_e3",  32'(bin),       32'h5);
      wait_edges(1);
      chk("mid_rewarm_e4", 32'(bin_valid), 32'd1);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
